// File: rtl/output_ctrl_pkg.sv
// Shared definitions for the output drain controller: state encoding,
// tile length width and the width helpers for the rotation and drain counters.
package output_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } drain_state_t;

   localparam int K_LEN_W = 16;

   function automatic int rot_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   // One extra bit so the drain index reaches 2*SIZE-2 without wrapping.
   function automatic int d_width(input int size);
      return $clog2(2 * size);
   endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Diagonal lane-valid mask: lane i holds a result while the drain index d
// lies in the window [i, i+SIZE).
module lane_mask_gen #(
   parameter int SIZE = 8,
   parameter int D_W  = 4
) (
   input  logic [D_W-1:0]  d,
   output logic [SIZE-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < SIZE; i++) begin
         mask[i] = (int'(d) >= i) && (int'(d) < i + SIZE);
      end
   end

endmodule

// File: rtl/output_drain_ctrl.sv
// Drains a SIZE x SIZE systolic result tile diagonally after a k_len-cycle fill.
// Define OUTPUT_DRAIN_REG_EN to add one register stage on the drain outputs and done.
module output_drain_ctrl
   import output_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SIZE       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [K_LEN_W-1:0]           k_len,
   input  logic [DATA_WIDTH*SIZE-1:0]   in_row,
   output logic [rot_width(SIZE)-1:0]   rot,
   output logic [DATA_WIDTH*SIZE-1:0]   out_data,
   output logic [SIZE-1:0]              out_mask,
   output logic                         out_valid,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done,
   output logic                         start_err
);

   localparam int RW = rot_width(SIZE);
   localparam int DW = d_width(SIZE);
   localparam logic [DW-1:0] D_LAST = DW'(2 * SIZE - 2);

   drain_state_t state, state_next;
   logic [K_LEN_W-1:0]         fill_cnt;
   logic [DW-1:0]              d;
   logic [SIZE-1:0]            lane_mask;
   logic                       drain_valid;
   logic                       drain_last;
   logic                       tile_done;
   logic [DATA_WIDTH*SIZE-1:0] drain_data;
   logic [SIZE-1:0]            drain_mask;

   lane_mask_gen #(
      .SIZE (SIZE),
      .D_W  (DW)
   ) u_lane_mask_gen (
      .d    (d),
      .mask (lane_mask)
   );

   always_comb begin
      state_next  = state;
      drain_valid = 1'b0;
      drain_last  = 1'b0;
      tile_done   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (k_len == '0) ? DRAIN : FILL;
            end
         end
         FILL: begin
            if (fill_cnt == K_LEN_W'(1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            drain_valid = 1'b1;
            if (d == D_LAST) begin
               drain_last = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            tile_done  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // rot restarts at 0 on acceptance and free-runs while a tile is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fill_cnt  <= '0;
         d         <= '0;
         rot       <= '0;
         start_err <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            if (start) begin
               fill_cnt <= k_len;
               rot      <= '0;
            end
         end else begin
            rot <= rot + RW'(1);
            if (start) begin
               start_err <= 1'b1;
            end
         end
         if (state == FILL) begin
            fill_cnt <= fill_cnt - K_LEN_W'(1);
         end
         if (state == DRAIN) begin
            d <= drain_last ? '0 : d + DW'(1);
         end
      end
   end

   assign busy       = (state != IDLE);
   assign drain_data = drain_valid ? in_row : '0;
   assign drain_mask = drain_valid ? lane_mask : '0;

`ifdef OUTPUT_DRAIN_REG_EN
   // done moves with the data stage so it still trails the registered out_last.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_mask  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         out_data  <= drain_data;
         out_mask  <= drain_mask;
         out_valid <= drain_valid;
         out_last  <= drain_last;
         done      <= tile_done;
      end
   end
`else
   always_comb begin
      out_data  = drain_data;
      out_mask  = drain_mask;
      out_valid = drain_valid;
      out_last  = drain_last;
      done      = tile_done;
   end
`endif

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Self-checking bench for output_drain_ctrl (SIZE=4, DATA_WIDTH=8) against a
// tile-timeline reference model; follows OUTPUT_DRAIN_REG_EN when defined.
module tb_output_drain_ctrl;

   localparam int DW_T = 8;
   localparam int S    = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic [15:0]       k_len;
   logic [DW_T*S-1:0] in_row;
   logic [1:0]        rot;
   logic [DW_T*S-1:0] out_data;
   logic [S-1:0]      out_mask;
   logic              out_valid;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              start_err;

   int compared   = 0;
   int mismatched = 0;

   bit  active;
   int  age;
   int  kk;
   int  rot_m;
   bit  err_m;

   logic              e_busy, e_done, e_valid, e_last;
   logic [S-1:0]      e_mask;
   logic [DW_T*S-1:0] e_data;
   logic              p_done, p_valid, p_last;
   logic [S-1:0]      p_mask;
   logic [DW_T*S-1:0] p_data;

   output_drain_ctrl #(
      .DATA_WIDTH (DW_T),
      .SIZE       (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .in_row    (in_row),
      .rot       (rot),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .start_err (start_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile timeline from acceptance: ages 1..K fill, next 2S-1 ages drain, then done.
   task automatic computeExpected();
      int beat;
      e_busy  = active;
      e_done  = active && (age == kk + 2 * S);
      e_valid = active && (age >= kk + 1) && (age <= kk + 2 * S - 1);
      beat    = age - kk - 1;
      e_last  = e_valid && (beat == 2 * S - 2);
      e_mask  = '0;
      for (int i = 0; i < S; i++) begin
         e_mask[i] = e_valid && (beat >= i) && (beat < i + S);
      end
      e_data = e_valid ? in_row : '0;
   endtask

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput();
      computeExpected();
      cmp("busy", 64'(busy), 64'(e_busy));
      cmp("rot", 64'(rot), 64'(rot_m[1:0]));
      cmp("start_err", 64'(start_err), 64'(err_m));
`ifdef OUTPUT_DRAIN_REG_EN
      cmp("done", 64'(done), 64'(p_done));
      cmp("out_valid", 64'(out_valid), 64'(p_valid));
      cmp("out_last", 64'(out_last), 64'(p_last));
      cmp("out_mask", 64'(out_mask), 64'(p_mask));
      cmp("out_data", 64'(out_data), 64'(p_data));
`else
      cmp("done", 64'(done), 64'(e_done));
      cmp("out_valid", 64'(out_valid), 64'(e_valid));
      cmp("out_last", 64'(out_last), 64'(e_last));
      cmp("out_mask", 64'(out_mask), 64'(e_mask));
      cmp("out_data", 64'(out_data), 64'(e_data));
`endif
   endtask

   task automatic modelUpdate(input logic r, input logic s, input logic [15:0] k);
      if (r) begin
         active = 0; age = 0; rot_m = 0; err_m = 0;
         p_done = 0; p_valid = 0; p_last = 0; p_mask = '0; p_data = '0;
      end else begin
         computeExpected();
         p_done = e_done; p_valid = e_valid; p_last = e_last;
         p_mask = e_mask; p_data = e_data;
         if (active) begin
            if (s) err_m = 1;
            rot_m = (rot_m + 1) % S;
            if (age == kk + 2 * S) active = 0;
            else age++;
         end else if (s) begin
            active = 1; age = 1; kk = int'(k); rot_m = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic [15:0] k);
      rst    = r;
      start  = s;
      k_len  = k;
      in_row = $urandom;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      modelUpdate(r, s, k);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; in_row = '0;
      active = 0; age = 0; kk = 0; rot_m = 0; err_m = 0;
      p_done = 0; p_valid = 0; p_last = 0; p_mask = '0; p_data = '0;
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b0, 16'd0);

      $display("[TB] tile k_len=3");
      applyStimulus(1'b0, 1'b1, 16'd3);
      repeat (14) applyStimulus(1'b0, 1'b0, 16'd0);

      $display("[TB] tile k_len=0");
      applyStimulus(1'b0, 1'b1, 16'd0);
      repeat (10) applyStimulus(1'b0, 1'b0, 16'd0);

      $display("[TB] start re-pulsed during drain");
      applyStimulus(1'b0, 1'b1, 16'd2);
      repeat (4) applyStimulus(1'b0, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b1, 16'd7);
      repeat (10) applyStimulus(1'b0, 1'b0, 16'd0);

      $display("[TB] reset at drain beat 3");
      applyStimulus(1'b0, 1'b1, 16'd1);
      repeat (4) applyStimulus(1'b0, 1'b0, 16'd0);
      applyStimulus(1'b1, 1'b1, 16'd5);
      repeat (4) applyStimulus(1'b0, 1'b0, 16'd0);

      $display("[TB] back-to-back tiles, start held");
      repeat (30) applyStimulus(1'b0, 1'b1, 16'd2);
      applyStimulus(1'b1, 1'b0, 16'd0);

      $display("[TB] k_len=65535 then reset");
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      repeat (20) applyStimulus(1'b0, 1'b0, 16'd0);
      applyStimulus(1'b1, 1'b0, 16'd0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 96) == 0), ($urandom_range(0, 5) == 0),
                       16'($urandom_range(0, 6)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
